lsu: RTL and testbench

Load/store unit for the RV32I core, downstream of the decoder in the execute/memory stage. It accepts one memory operation at a time, described by the decoder's MemWrite and AddressingControl (funct3) outputs plus the ALU-computed address and rs2 data. It drives a word-wide data-memory handshake with byte enables and returns the sign- or zero-extended load result. It stalls the pipeline while an access is outstanding.

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_align.sv | 48 ++++
 rtl/lsu.sv | 168 ++++++++++++++++
 tb/tb_lsu.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM states, funct3 width codes,
// default access timeout and the request legality check.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  localparam int unsigned LSU_TIMEOUT = 255;

  // High when the request must be answered with an error instead of a memory access.
  function automatic logic ls_bad(input logic we, input logic [2:0] code, input logic [1:0] off);
    logic legal;
    logic mis;
    legal = (code == LS_B) || (code == LS_H) || (code == LS_W) ||
            (!we && ((code == LS_BU) || (code == LS_HU)));
    mis   = (((code == LS_H) || (code == LS_HU)) && off[0]) ||
            ((code == LS_W) && (off != 2'b00));
    return !legal || mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store-side byte enables and data replication,
// load-side lane extraction with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_off_i,
  input  logic [2:0]  st_code_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  input  logic [1:0]  ld_off_i,
  input  logic [2:0]  ld_code_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] lane;

  always_comb begin
    st_be_o    = 4'b1111;
    st_wdata_o = st_data_i;
    case (st_code_i[1:0])
      2'b00: begin
        st_be_o    = 4'b0001 << st_off_i;
        st_wdata_o = {4{st_data_i[7:0]}};
      end
      2'b01: begin
        st_be_o    = 4'b0011 << st_off_i;
        st_wdata_o = {2{st_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  assign lane = ld_rdata_i >> {ld_off_i, 3'b000};

  always_comb begin
    ld_data_o = lane;
    case (ld_code_i)
      LS_B:    ld_data_o = {{24{lane[7]}}, lane[7:0]};
      LS_H:    ld_data_o = {{16{lane[15]}}, lane[15:0]};
      LS_BU:   ld_data_o = {24'h0, lane[7:0]};
      LS_HU:   ld_data_o = {16'h0, lane[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one outstanding access, registered memory handshake,
// error response for illegal/misaligned requests or an unanswered access.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = LSU_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_addrctl,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  lsu_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  code_q, code_d;
  logic [1:0]  off_q, off_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;

  logic        req_bad;
  logic        timed_out;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;

  lsu_align u_align (
    .st_off_i   (req_addr[1:0]),
    .st_code_i  (req_addrctl),
    .st_data_i  (req_wdata),
    .st_be_o    (st_be),
    .st_wdata_o (st_wdata),
    .ld_off_i   (off_q),
    .ld_code_i  (code_q),
    .ld_rdata_i (mem_rdata),
    .ld_data_o  (ld_data)
  );

  assign req_bad   = ls_bad(req_we, req_addrctl, req_addr[1:0]);
  assign timed_out = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      code_q       <= '0;
      off_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      code_q       <= code_d;
      off_q        <= off_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Ack takes priority over the timeout in the final ACCESS cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = req_bad ? RESP : ACCESS;
      ACCESS:  if (mem_ack || timed_out) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d        = cnt_q;
    code_d       = code_q;
    off_d        = off_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = resp_rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_bad) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else begin
            cnt_d       = '0;
            code_d      = req_addrctl;
            off_d       = req_addr[1:0];
            mem_req_d   = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_wdata_d = st_wdata;
            mem_be_d    = req_we ? st_be : 4'b0000;
          end
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          mem_req_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_rdata_d = mem_we_q ? 32'h0 : ld_data;
        end else if (timed_out) begin
          mem_req_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  assign req_ready  = (state_q == IDLE);
  assign stall      = ((state_q == IDLE) && req_valid) || (state_q == ACCESS);
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_be     = mem_be_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_lsu.sv
// Randomised scoreboard bench for lsu with a small memory responder.
module tb_lsu;
  import lsu_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_addrctl;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, stall;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad = 0;

  logic [40:0] exp_q[$];      // {err, rdata, cycles with mem_req high}
  logic [68:0] exp_mem_q[$];  // {we, addr, wdata, be}

  int          ack_delay = 0; // ACCESS cycle that gets mem_ack; 0 = never
  logic [31:0] ack_data = '0;
  bit          stray_en = 0;

  lsu #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addrctl(req_addrctl), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // memory responder
  initial begin
    int cyc;
    cyc = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req) begin
        cyc++;
        mem_rdata = ack_data;
        if (cyc == ack_delay) mem_ack = 1'b1;
      end else begin
        cyc = 0;
        if (stray_en && $urandom_range(0, 3) == 0) begin
          mem_ack = 1'b1;
          mem_rdata = $urandom;
        end
      end
    end
  end

  // monitor
  initial begin
    int run;
    logic prev;
    logic [40:0] e;
    logic [68:0] m;
    run = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run = 0;
        prev = 1'b0;
      end else begin
        if (req_ready) chk("stall_idle", 64'(stall), 64'(req_valid));
        if (mem_req && !prev) begin
          if (exp_mem_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_mem_req: got addr %0h expected none", mem_addr);
          end else begin
            m = exp_mem_q.pop_front();
            chk("mem_we", 64'(mem_we), 64'(m[68]));
            chk("mem_addr", 64'(mem_addr), 64'(m[67:36]));
            if (m[68]) chk("mem_wdata", 64'(mem_wdata), 64'(m[35:4]));
            chk("mem_be", 64'(mem_be), 64'(m[3:0]));
          end
        end
        if (mem_req) begin
          run++;
          chk("stall_access", 64'(stall), 64'd1);
          chk("ready_access", 64'(req_ready), 64'd0);
        end
        if (resp_valid) begin
          chk("stall_resp", 64'(stall), 64'd0);
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_resp: got err %0b rdata %0h expected none", resp_err, resp_rdata);
          end else begin
            e = exp_q.pop_front();
            chk("resp_err", 64'(resp_err), 64'(e[40]));
            chk("resp_rdata", 64'(resp_rdata), 64'(e[39:8]));
            chk("req_cycles", 64'(run), 64'(e[7:0]));
          end
          run = 0;
        end
        prev = mem_req;
      end
    end
  end

  // driver: reference model computes expectations, then issues the request
  task automatic do_op(input bit we, input logic [2:0] code, input logic [31:0] addr,
                       input logic [31:0] wdata, input int delay, input logic [31:0] rdata);
    logic [1:0]  off;
    bit          legal, mis, err;
    int          nb, lat, exp_lat;
    bit          got;
    logic [3:0]  be;
    logic [31:0] wd, lane, mask, v;
    off   = addr[1:0];
    legal = (code inside {3'd0, 3'd1, 3'd2}) || (!we && (code inside {3'd4, 3'd5}));
    nb    = (code[1:0] == 2'd0) ? 1 : (code[1:0] == 2'd1) ? 2 : 4;
    mis   = (nb == 2 && off[0]) || (nb == 4 && off != 2'd0);
    err   = !legal || mis;
    be    = 4'(((1 << nb) - 1) << off);
    wd    = (nb == 1) ? wdata[7:0] * 32'h01010101 :
            (nb == 2) ? wdata[15:0] * 32'h00010001 : wdata;
    lane  = rdata >> (8 * off);
    mask  = (nb == 1) ? 32'hFF : (nb == 2) ? 32'hFFFF : 32'hFFFFFFFF;
    v     = lane & mask;
    if (!code[2] && nb < 4 && v > (mask >> 1)) v = v - mask - 32'd1;

    @(negedge clk); #1;
    for (int i = 0; i < 20 && !req_ready; i++) begin @(negedge clk); #1; end
    ack_delay = delay;
    ack_data  = rdata;
    if (err) begin
      exp_q.push_back({1'b1, 32'h0, 8'd0});
      exp_lat = 1;
    end else begin
      exp_mem_q.push_back({we, addr & 32'hFFFFFFFC, wd, we ? be : 4'b0000});
      if (delay == 0 || delay > TO) begin
        exp_q.push_back({1'b1, 32'h0, 8'(TO)});
        exp_lat = TO + 1;
      end else begin
        exp_q.push_back({1'b0, we ? 32'h0 : v, 8'(delay)});
        exp_lat = delay + 1;
      end
    end
    req_we = we; req_addrctl = code; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    got = 0;
    lat = 0;
    for (int i = 0; i < TO + 20 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (resp_valid) got = 1;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL resp_wait: got no resp_valid expected one within %0d cycles", TO + 20);
    end else begin
      chk("latency", 64'(lat), 64'(exp_lat));
    end
    req_valid = 1'b0;
  endtask

  // main sequence
  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_addrctl = '0; req_addr = '0; req_wdata = '0;
    #12;
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_mem_be", 64'(mem_be), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_resp_rdata", 64'(resp_rdata), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(1'b1, 3'b000, 32'h1003, 32'hAABBCCDD, 1, 32'h0);
    do_op(1'b0, 3'b000, 32'h2002, 32'h0, 1, 32'h00800000);
    do_op(1'b0, 3'b100, 32'h2002, 32'h0, 2, 32'h00800000);
    do_op(1'b0, 3'b001, 32'h2002, 32'h0, 1, 32'h80010000);
    do_op(1'b0, 3'b010, 32'h3001, 32'h0, 1, 32'h0);
    do_op(1'b1, 3'b100, 32'h1000, 32'h12345678, 1, 32'h0);
    do_op(1'b1, 3'b001, 32'h1002, 32'h00005A5A, 3, 32'h0);
    do_op(1'b0, 3'b010, 32'h0040, 32'h0, 0, 32'hDEADBEEF);
    do_op(1'b0, 3'b010, 32'h0044, 32'h0, TO, 32'h12345678);

    // reset in the middle of an access
    @(negedge clk); #1;
    ack_delay = 0;
    exp_mem_q.push_back({1'b0, 32'h100, 32'h0, 4'b0000});
    req_we = 1'b0; req_addrctl = 3'b010; req_addr = 32'h100; req_wdata = 32'h0;
    req_valid = 1'b1;
    @(negedge clk);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    req_valid = 1'b0;
    #1;
    chk("arst_mem_req", 64'(mem_req), 64'd0);
    chk("arst_req_ready", 64'(req_ready), 64'd1);
    chk("arst_resp_valid", 64'(resp_valid), 64'd0);
    chk("arst_stall", 64'(stall), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(1'b0, 3'b010, 32'h0050, 32'h0, 3, 32'hCAFEF00D);
    do_op(1'b0, 3'b010, 32'h0054, 32'h0, 3, 32'h0BADF00D);

    stray_en = 1;
    for (int n = 0; n < 200; n++) begin
      logic [2:0] code;
      code = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) :
             (($urandom_range(0, 4) == 0) ? 3'b100 : 3'($urandom_range(0, 2)));
      if ($urandom_range(0, 5) == 0) code = 3'b101;
      do_op(1'($urandom_range(0, 1)), code, $urandom, $urandom,
            $urandom_range(0, TO + 2), $urandom);
    end

    repeat (4) @(negedge clk);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    chk("exp_mem_q_drained", 64'(exp_mem_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
